// File: rtl/wheel_distance_sampler.sv
// rtl/wheel_distance_sampler.sv - dual-wheel X4 quadrature decode, windowed tick count and micrometer scaling
// Optional feature macro: QUAD_ERROR_EN (illegal quadrature transition detection and quad_error reporting)
module wheel_distance_sampler #(
  parameter int SAMPLE_PERIOD_CYCLES = 500000,
  parameter int UM_PER_TICK          = 500,
  parameter int CNT_WIDTH            = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               enc_left_a,
  input  logic               enc_left_b,
  input  logic               enc_right_a,
  input  logic               enc_right_b,
  output logic signed [31:0] distance_left,
  output logic signed [31:0] distance_right,
  output logic               sample_valid,
  output logic               overflow,
  output logic               quad_error
);

  localparam int TW = (SAMPLE_PERIOD_CYCLES > 1) ? $clog2(SAMPLE_PERIOD_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD_CYCLES - 1);
  localparam logic signed [CNT_WIDTH-1:0] CNT_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic signed [CNT_WIDTH-1:0] CNT_MIN = -CNT_MAX;
  localparam logic signed [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic signed [31:0] UM_SCALE = 32'(UM_PER_TICK);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_SCALE,
    ST_PUBLISH
  } state_t;

  // Position of an AB pair along the forward sequence 00,01,11,10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  // Saturating single step; returns {hit_while_saturated, new_value}.
  function automatic logic [CNT_WIDTH:0] sat_step(input logic signed [CNT_WIDTH-1:0] cnt,
                                                  input logic inc, input logic dec);
    logic [CNT_WIDTH:0] r;
    r = {1'b0, cnt};
    if (inc) begin
      if (cnt == CNT_MAX) r[CNT_WIDTH] = 1'b1;
      else                r[CNT_WIDTH-1:0] = cnt + CNT_ONE;
    end else if (dec) begin
      if (cnt == CNT_MIN) r[CNT_WIDTH] = 1'b1;
      else                r[CNT_WIDTH-1:0] = cnt - CNT_ONE;
    end
    return r;
  endfunction

  // Raw step used to seed a fresh window on the capture cycle.
  function automatic logic signed [CNT_WIDTH-1:0] step_val(input logic inc, input logic dec);
    logic signed [CNT_WIDTH-1:0] v;
    v = '0;
    if (inc)      v = CNT_ONE;
    else if (dec) v = -CNT_ONE;
    return v;
  endfunction

  logic [1:0] sync1_l_q, sync2_l_q, prev_l_q;
  logic [1:0] sync1_r_q, sync2_r_q, prev_r_q;
  logic [1:0] dpos_l, dpos_r;
  logic       inc_l, dec_l, inc_r, dec_r;

  logic [TW-1:0]               timer_q, timer_d;
  logic signed [CNT_WIDTH-1:0] cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
  logic signed [CNT_WIDTH-1:0] sat_l_val, sat_r_val;
  logic                        sat_l_hit, sat_r_hit;
  logic                        ovf_q, ovf_d;
  logic                        capture;

  logic signed [CNT_WIDTH-1:0] snap_l_q, snap_r_q;
  logic                        snap_ovf_q;
  logic signed [31:0]          snap_l_ext, snap_r_ext;
  logic signed [31:0]          scale_l_q, scale_r_q;

  state_t state_q, state_d;
  logic   scale_en, publish_en;

`ifdef QUAD_ERROR_EN
  logic ill_l, ill_r;
  logic qerr_q, qerr_d;
  logic snap_qerr_q;
  logic quad_error_q;
`endif

  // Two-stage synchronizers plus the previous synchronized pair for the decoder.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_l_q <= '0;
      sync2_l_q <= '0;
      prev_l_q  <= '0;
      sync1_r_q <= '0;
      sync2_r_q <= '0;
      prev_r_q  <= '0;
    end else begin
      sync1_l_q <= {enc_left_a, enc_left_b};
      sync2_l_q <= sync1_l_q;
      prev_l_q  <= sync2_l_q;
      sync1_r_q <= {enc_right_a, enc_right_b};
      sync2_r_q <= sync1_r_q;
      prev_r_q  <= sync2_r_q;
    end
  end

  // X4 decode: a position delta of 1 is forward, 3 is reverse, 2 is a double-bit jump.
  always_comb begin
    dpos_l = gray_pos(sync2_l_q) - gray_pos(prev_l_q);
    dpos_r = gray_pos(sync2_r_q) - gray_pos(prev_r_q);
    inc_l  = (dpos_l == 2'd1);
    dec_l  = (dpos_l == 2'd3);
    inc_r  = (dpos_r == 2'd1);
    dec_r  = (dpos_r == 2'd3);
  end

`ifdef QUAD_ERROR_EN
  assign ill_l = (dpos_l == 2'd2);
  assign ill_r = (dpos_r == 2'd2);
`endif

  assign capture = enable && (timer_q == TIMER_LAST);

  // Window timer, saturating tick counters and window flags; capture reseeds with this cycle's step.
  always_comb begin
    {sat_l_hit, sat_l_val} = sat_step(cnt_l_q, inc_l, dec_l);
    {sat_r_hit, sat_r_val} = sat_step(cnt_r_q, inc_r, dec_r);
    timer_d = timer_q + 1'b1;
    cnt_l_d = sat_l_val;
    cnt_r_d = sat_r_val;
    ovf_d   = ovf_q | sat_l_hit | sat_r_hit;
`ifdef QUAD_ERROR_EN
    qerr_d  = qerr_q | ill_l | ill_r;
`endif
    if (capture) begin
      timer_d = '0;
      cnt_l_d = step_val(inc_l, dec_l);
      cnt_r_d = step_val(inc_r, dec_r);
      // A counter reseeded from zero with a single step cannot saturate.
      ovf_d   = 1'b0;
`ifdef QUAD_ERROR_EN
      qerr_d  = ill_l | ill_r;
`endif
    end
    if (!enable) begin
      timer_d = '0;
      cnt_l_d = '0;
      cnt_r_d = '0;
      ovf_d   = 1'b0;
`ifdef QUAD_ERROR_EN
      qerr_d  = 1'b0;
`endif
    end
  end

  // Counting state registers and the capture snapshot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q    <= '0;
      cnt_l_q    <= '0;
      cnt_r_q    <= '0;
      ovf_q      <= 1'b0;
      snap_l_q   <= '0;
      snap_r_q   <= '0;
      snap_ovf_q <= 1'b0;
`ifdef QUAD_ERROR_EN
      qerr_q      <= 1'b0;
      snap_qerr_q <= 1'b0;
`endif
    end else begin
      timer_q <= timer_d;
      cnt_l_q <= cnt_l_d;
      cnt_r_q <= cnt_r_d;
      ovf_q   <= ovf_d;
`ifdef QUAD_ERROR_EN
      qerr_q  <= qerr_d;
`endif
      if (capture) begin
        snap_l_q   <= cnt_l_q;
        snap_r_q   <= cnt_r_q;
        snap_ovf_q <= ovf_q;
`ifdef QUAD_ERROR_EN
        snap_qerr_q <= qerr_q;
`endif
      end
    end
  end

  // Output FSM next state; enable low forces IDLE and suppresses any pending scale/publish.
  always_comb begin
    state_d    = state_q;
    scale_en   = 1'b0;
    publish_en = 1'b0;
    case (state_q)
      ST_IDLE:    if (enable) state_d = ST_COUNT;
      ST_COUNT:   if (capture) state_d = ST_SCALE;
      ST_SCALE: begin
        scale_en = 1'b1;
        state_d  = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        publish_en = 1'b1;
        state_d    = ST_COUNT;
      end
      default:    state_d = ST_IDLE;
    endcase
    if (!enable) begin
      state_d    = ST_IDLE;
      scale_en   = 1'b0;
      publish_en = 1'b0;
    end
  end

  // Output FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Sign-extend before scaling so the 32-bit product keeps the direction.
  assign snap_l_ext = 32'(snap_l_q);
  assign snap_r_ext = 32'(snap_r_q);

  // Scale stage: ticks times micrometers per tick, truncated to 32 bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scale_l_q <= '0;
      scale_r_q <= '0;
    end else if (scale_en) begin
      scale_l_q <= snap_l_ext * UM_SCALE;
      scale_r_q <= snap_r_ext * UM_SCALE;
    end
  end

  // Publish stage: outputs change only here and hold otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      distance_left  <= '0;
      distance_right <= '0;
      overflow       <= 1'b0;
      sample_valid   <= 1'b0;
    end else begin
      sample_valid <= publish_en;
      if (publish_en) begin
        distance_left  <= scale_l_q;
        distance_right <= scale_r_q;
        overflow       <= snap_ovf_q;
      end
    end
  end

`ifdef QUAD_ERROR_EN
  // Published illegal-transition flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        quad_error_q <= 1'b0;
    else if (publish_en) quad_error_q <= snap_qerr_q;
  end
  assign quad_error = quad_error_q;
`else
  assign quad_error = 1'b0;
`endif

endmodule
